// File: rtl/pow_pkg.sv
// Shared types, default widths and a reference evaluator for the sequential
// signed exponentiation unit.
package pow_pkg;

   localparam int unsigned POW_WIDTH  = 8;
   localparam int unsigned POW_EWIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } pow_state_t;

   typedef struct packed {
      logic                 undef;
      logic [POW_WIDTH-1:0] y;
   } pow_res_t;

   // Plain repeated-multiplication evaluator at the default widths.
   function automatic pow_res_t pow_ref(input logic [POW_WIDTH-1:0]  base,
                                        input logic [POW_EWIDTH-1:0] exp,
                                        input logic                  exp_signed);
      pow_res_t             r;
      logic [POW_WIDTH-1:0] acc;
      r.undef = 1'b0;
      acc     = POW_WIDTH'(1);
      if (exp_signed && exp[POW_EWIDTH-1]) begin
         if (base == POW_WIDTH'(1)) begin
            acc = POW_WIDTH'(1);
         end else if (base == '1) begin
            acc = exp[0] ? '1 : POW_WIDTH'(1);
         end else begin
            acc     = '0;
            r.undef = (base == '0);
         end
      end else begin
         for (int i = 0; i < int'(exp); i++) begin
            acc = POW_WIDTH'(acc * base);
         end
      end
      r.y = acc;
      return r;
   endfunction

endpackage

// File: rtl/pow_special.sv
// Detects zero and negative exponents and produces their fixed results
// without iterating.
module pow_special
   import pow_pkg::*;
#(
   parameter int unsigned WIDTH  = POW_WIDTH,
   parameter int unsigned EWIDTH = POW_EWIDTH
) (
   input  logic [WIDTH-1:0]  base_i,
   input  logic [EWIDTH-1:0] exp_i,
   input  logic              exp_signed_i,
   output logic              is_special_c,
   output logic [WIDTH-1:0]  y_c,
   output logic              y_undef_c
);

   logic neg_exp;
   logic zero_exp;

   assign neg_exp  = exp_signed_i & exp_i[EWIDTH-1];
   assign zero_exp = (exp_i == '0);

   always_comb begin
      is_special_c = neg_exp | zero_exp;
      y_c          = '0;
      y_undef_c    = 1'b0;
      if (zero_exp) begin
         y_c = WIDTH'(1);
      end else if (neg_exp) begin
         // Only +1 and -1 have a non-zero integer reciprocal power.
         if (base_i == WIDTH'(1)) begin
            y_c = WIDTH'(1);
         end else if (base_i == '1) begin
            y_c = exp_i[0] ? '1 : WIDTH'(1);
         end else if (base_i == '0) begin
            y_undef_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pow_seq.sv
// Sequential signed integer exponentiation y = base ** exp (modulo 2^WIDTH),
// LSB-first square-and-multiply with valid/ready on both sides.
module pow_seq
   import pow_pkg::*;
#(
   parameter int unsigned WIDTH  = POW_WIDTH,
   parameter int unsigned EWIDTH = POW_EWIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  base,
   input  logic [EWIDTH-1:0] exp,
   input  logic              exp_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  y,
   output logic              y_undef
);

   pow_state_t        state_q;
   logic [WIDTH-1:0]  acc_q;
   logic [WIDTH-1:0]  b_q;
   logic [EWIDTH-1:0] e_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [WIDTH-1:0]  y_q;
   logic              y_undef_q;

   logic              sp_is_c;
   logic [WIDTH-1:0]  sp_y_c;
   logic              sp_undef_c;

   logic [WIDTH-1:0]  step_acc;
   logic [WIDTH-1:0]  step_b;
   logic [EWIDTH-1:0] step_e;
   logic [WIDTH-1:0]  acc_d;
   logic [WIDTH-1:0]  b_d;
   logic [EWIDTH-1:0] e_d;

   pow_special #(
      .WIDTH  (WIDTH),
      .EWIDTH (EWIDTH)
   ) u_special (
      .base_i       (base),
      .exp_i        (exp),
      .exp_signed_i (exp_signed),
      .is_special_c (sp_is_c),
      .y_c          (sp_y_c),
      .y_undef_c    (sp_undef_c)
   );

   // One square-and-multiply step. In IDLE it starts from (1, base, exp), so
   // the first exponent bit is consumed on the accept edge and latency is L.
   always_comb begin
      step_acc = acc_q;
      step_b   = b_q;
      step_e   = e_q;
      if (state_q == IDLE) begin
         step_acc = WIDTH'(1);
         step_b   = base;
         step_e   = exp;
      end
      acc_d = step_e[0] ? WIDTH'(step_acc * step_b) : step_acc;
      b_d   = WIDTH'(step_b * step_b);
      e_d   = step_e >> 1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         b_q         <= '0;
         e_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         y_undef_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  if (sp_is_c) begin
                     y_q         <= sp_y_c;
                     y_undef_q   <= sp_undef_c;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     acc_q     <= acc_d;
                     b_q       <= b_d;
                     e_q       <= e_d;
                     y_undef_q <= 1'b0;
                     if (e_d == '0) begin
                        y_q         <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                     end else begin
                        state_q <= RUN;
                     end
                  end
               end
            end
            RUN: begin
               acc_q <= acc_d;
               b_q   <= b_d;
               e_q   <= e_d;
               if (e_d == '0) begin
                  y_q         <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign y_undef   = y_undef_q;

endmodule

// File: tb/tb_pow_seq.sv
// Self-checking bench for pow_seq: directed vector table, backpressure and
// reset sequences, then randomized operands against an arithmetic model.
module tb_pow_seq;
   import pow_pkg::*;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       in_valid   = 1'b0;
   logic       exp_signed = 1'b0;
   logic       out_ready  = 1'b0;
   logic [7:0] base       = 8'h00;
   logic [7:0] exp        = 8'h00;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] y;
   logic       y_undef;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      nm;
      logic [7:0] b;
      logic [7:0] e;
      logic       es;
      logic [7:0] y;
      logic       u;
      int         lat;
   } vec_t;

   vec_t vecs[$];

   pow_seq #(.WIDTH(8), .EWIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .base       (base),
      .exp        (exp),
      .exp_signed (exp_signed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .y          (y),
      .y_undef    (y_undef)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   // Language-level value of base ** exp: {undef, y}.
   function automatic logic [8:0] model(input logic [7:0] b, input logic [7:0] e, input logic es);
      int sb;
      int r;
      sb = $signed(b);
      if (es && e[7]) begin
         if (sb == 1)  return 9'h001;
         if (sb == -1) return e[0] ? 9'h0FF : 9'h001;
         if (sb == 0)  return 9'h100;
         return 9'h000;
      end
      r = 1;
      for (int i = 0; i < int'(e); i++) r = (r * sb) & 255;
      return {1'b0, 8'(r)};
   endfunction

   function automatic int lat_model(input logic [7:0] e, input logic es);
      int l;
      if ((es && e[7]) || e == 8'h00) return 1;
      l = 0;
      for (int i = 0; i < 8; i++) if (e[i]) l = i + 1;
      return l;
   endfunction

   // One request/response; stall > 0 holds out_ready low in DONE while
   // presenting requests that must be ignored.
   task automatic run_op(input string nm, input logic [7:0] b, input logic [7:0] e,
                         input logic es, input logic [7:0] want_y, input logic want_u,
                         input int want_lat, input int stall);
      int         n;
      int         lat;
      logic [7:0] yc;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL %s: in_ready timeout got 0 want 1", nm);
         return;
      end
      base       = b;
      exp        = e;
      exp_signed = es;
      in_valid   = 1'b1;
      out_ready  = (stall == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL %s: out_valid timeout got 0 want 1", nm);
         return;
      end
      chk({nm, " y"}, 32'(y), 32'(want_y));
      chk({nm, " y_undef"}, 32'(y_undef), 32'(want_u));
      chk({nm, " latency"}, 32'(lat), 32'(want_lat));
      yc = y;
      for (int i = 0; i < stall; i++) begin
         in_valid   = 1'b1;
         base       = 8'($urandom);
         exp        = 8'($urandom);
         exp_signed = 1'($urandom);
         @(posedge clk); #1;
         chk({nm, " hold y"}, 32'(y), 32'(yc));
         chk({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
         chk({nm, " hold in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({nm, " in_ready after"}, 32'(in_ready), 32'd1);
      chk({nm, " out_valid after"}, 32'(out_valid), 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] rb;
      logic [7:0] re;
      logic       res;
      logic [8:0] m;
      pow_res_t   pr;
      int         stall;

      vecs.push_back('{"1**-2",     8'h01, 8'hFE, 1'b1, 8'h01, 1'b0, 1});
      vecs.push_back('{"2**-2",     8'h02, 8'hFE, 1'b1, 8'h00, 1'b0, 1});
      vecs.push_back('{"-2**-3",    8'hFE, 8'hFD, 1'b1, 8'h00, 1'b0, 1});
      vecs.push_back('{"-1**-3",    8'hFF, 8'hFD, 1'b1, 8'hFF, 1'b0, 1});
      vecs.push_back('{"-1**-2",    8'hFF, 8'hFE, 1'b1, 8'h01, 1'b0, 1});
      vecs.push_back('{"3**5",      8'h03, 8'h05, 1'b0, 8'hF3, 1'b0, 3});
      vecs.push_back('{"-3**3",     8'hFD, 8'h03, 1'b1, 8'hE5, 1'b0, 2});
      vecs.push_back('{"2**8u",     8'h02, 8'h08, 1'b0, 8'h00, 1'b0, 4});
      vecs.push_back('{"0**0",      8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 1});
      vecs.push_back('{"0**-1",     8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1});
      vecs.push_back('{"0**7",      8'h00, 8'h07, 1'b0, 8'h00, 1'b0, 3});
      vecs.push_back('{"5**1",      8'h05, 8'h01, 1'b0, 8'h05, 1'b0, 1});
      vecs.push_back('{"3**127s",   8'h03, 8'h7F, 1'b1, 8'hAB, 1'b0, 7});
      vecs.push_back('{"-1**255u",  8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 8});
      vecs.push_back('{"-128**-128",8'h80, 8'h80, 1'b1, 8'h00, 1'b0, 1});

      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset y", 32'(y), 32'd0);
      chk("reset y_undef", 32'(y_undef), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].nm, vecs[i].b, vecs[i].e, vecs[i].es,
                vecs[i].y, vecs[i].u, vecs[i].lat, 0);
      end

      run_op("backpressure 3**5", 8'h03, 8'h05, 1'b0, 8'hF3, 1'b0, 3, 5);

      // Reset in the middle of a long RUN discards the operation.
      base = 8'h03; exp = 8'h7F; exp_signed = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid-run busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid-run reset in_ready", 32'(in_ready), 32'd1);
      chk("mid-run reset out_valid", 32'(out_valid), 32'd0);
      chk("mid-run reset y", 32'(y), 32'd0);
      chk("mid-run reset y_undef", 32'(y_undef), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("post-reset no result", 32'(out_valid), 32'd0);
      run_op("post-reset 2**3", 8'h02, 8'h03, 1'b0, 8'h08, 1'b0, 2, 0);

      for (int k = 0; k < 10000; k++) begin
         rb  = 8'($urandom);
         res = 1'($urandom);
         case ($urandom % 4)
            0:       re = 8'($urandom);
            1:       re = 8'($urandom_range(128, 255));
            default: re = 8'($urandom_range(0, 15));
         endcase
         m  = model(rb, re, res);
         pr = pow_ref(rb, re, res);
         chk("pow_ref", 32'(pr), 32'(m));
         stall = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
         run_op("rand", rb, re, res, m[7:0], m[8], lat_model(re, res), stall);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
